// File: rtl/rmlen_pkg.sv
// Shared types and constants for the reception data length sequencer.
package rmlen_pkg;

    localparam int unsigned DLC_BITS       = 4;
    localparam int unsigned MAX_DATA_BYTES = 8;
    localparam int unsigned SETRM_W        = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COLLECT = 3'd2,
        LOAD    = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_e;

    typedef logic [SETRM_W-1:0] setrm_t;

    localparam setrm_t SETRM_NONE = 3'd0;
    localparam setrm_t SETRM_B0   = 3'd1;
    localparam setrm_t SETRM_B1   = 3'd2;
    localparam setrm_t SETRM_B2   = 3'd3;
    localparam setrm_t SETRM_B3   = 3'd4;

    // Register bit-select code for the lowest set bit of a pending mask.
    function automatic setrm_t lowest_code(input logic [DLC_BITS-1:0] mask);
        setrm_t code;
        code = SETRM_NONE;
        if (mask[3]) code = SETRM_B3;
        if (mask[2]) code = SETRM_B2;
        if (mask[1]) code = SETRM_B1;
        if (mask[0]) code = SETRM_B0;
        return code;
    endfunction

    function automatic logic [DLC_BITS-1:0] drop_lowest(input logic [DLC_BITS-1:0] mask);
        return mask & (mask - DLC_BITS'(1));
    endfunction

endpackage

// File: rtl/rmlen_calc.sv
// Payload length from {rtr, dlc}. RMLEN_RAW_DLC_EN removes the clamp of DLC 9..15 to 8.
module rmlen_calc
    import rmlen_pkg::*;
(
    input  logic                rtr_i,
    input  logic [DLC_BITS-1:0] dlc_i,
    output logic [DLC_BITS-1:0] len_c
);

    always_comb begin
        len_c = dlc_i;
`ifdef RMLEN_RAW_DLC_EN
        len_c = dlc_i;
`else
        if (dlc_i > DLC_BITS'(MAX_DATA_BYTES)) begin
            len_c = DLC_BITS'(MAX_DATA_BYTES);
        end
`endif
        if (rtr_i) begin
            len_c = '0;
        end
    end

endmodule

// File: rtl/rmlen_seq.sv
// Collects DLC/RTR, then programs the length register one bit per activation pulse.
// Optional macro RMLEN_RAW_DLC_EN (via rmlen_calc) disables clamping of DLC 9..15.
module rmlen_seq
    import rmlen_pkg::*;
#(
    parameter int unsigned SET_GAP       = 1,
    parameter bit          DLC_MSB_FIRST = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sof,
    input  logic                abort,
    input  logic                rtr_bit,
    input  logic                rtr_valid,
    input  logic                dlc_bit,
    input  logic                dlc_valid,
    output logic                actvrmlen,
    output logic                resrmlen,
    output logic [SETRM_W-1:0]  setrmlen,
    output logic [DLC_BITS-1:0] dlc,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CNT_W = $clog2(DLC_BITS);
    localparam int unsigned GAP_W = 2;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(SET_GAP - 1);

    state_e              state_q, state_d;
    logic [DLC_BITS-1:0] dlc_q, dlc_d, dlc_base, dlc_new;
    logic [DLC_BITS-1:0] pend_q, pend_d, len_c;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                rtr_q, rtr_d, rtr_base, rtr_new, last_bit;
    logic                actv_q, actv_d, res_q, res_d, busy_q, busy_d, done_q, done_d;
    setrm_t              set_q, set_d;

    // Capture path: CLEAR sees zeroed fields so a same-cycle valid still lands.
    always_comb begin
        dlc_base = (state_q == CLEAR) ? '0 : dlc_q;
        rtr_base = (state_q == CLEAR) ? 1'b0 : rtr_q;
        cnt_base = (state_q == CLEAR) ? '0 : cnt_q;
        dlc_new  = dlc_base;
        if (dlc_valid) begin
            if (DLC_MSB_FIRST) dlc_new = {dlc_base[DLC_BITS-2:0], dlc_bit};
            else               dlc_new = {dlc_bit, dlc_base[DLC_BITS-1:1]};
        end
        rtr_new  = rtr_valid ? rtr_bit : rtr_base;
        last_bit = dlc_valid && (cnt_base == CNT_W'(DLC_BITS - 1));
    end

    rmlen_calc u_calc (
        .rtr_i (rtr_new),
        .dlc_i (dlc_new),
        .len_c (len_c)
    );

    always_comb begin
        state_d = state_q;
        dlc_d   = dlc_q;
        rtr_d   = rtr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        set_d   = SETRM_NONE;
        actv_d  = 1'b0;
        res_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            CLEAR, COLLECT: begin
                dlc_d   = dlc_new;
                rtr_d   = rtr_new;
                cnt_d   = cnt_base + CNT_W'(dlc_valid);
                pend_d  = '0;
                state_d = COLLECT;
                if (last_bit) begin
                    if (len_c != '0) begin
                        state_d = LOAD;
                        set_d   = lowest_code(len_c);
                        pend_d  = drop_lowest(len_c);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                state_d = GAP;
                gap_d   = GAP_INIT;
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (pend_q != '0) begin
                        state_d = LOAD;
                        set_d   = lowest_code(pend_q);
                        pend_d  = drop_lowest(pend_q);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // sof restarts from anywhere and wins over abort.
        if (sof) begin
            state_d = CLEAR;
            pend_d  = '0;
        end else if (abort) begin
            state_d = IDLE;
        end

        // Outputs are registered copies of the next state's decode.
        actv_d = (state_d == LOAD);
        if (!actv_d) set_d = SETRM_NONE;
        res_d  = (state_d != CLEAR);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dlc_q   <= '0;
            rtr_q   <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= '0;
            gap_q   <= '0;
            set_q   <= SETRM_NONE;
            actv_q  <= 1'b0;
            res_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dlc_q   <= dlc_d;
            rtr_q   <= rtr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            set_q   <= set_d;
            actv_q  <= actv_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign actvrmlen = actv_q;
    assign resrmlen  = res_q;
    assign setrmlen  = set_q;
    assign dlc       = dlc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rmlen_seq.sv
// Directed bench for rmlen_seq: frame table plus abort, sof-restart and async-reset sequences.
module tb_rmlen_seq;

    logic       clock;
    logic       reset;
    logic       sof, abort, rtr_bit, rtr_valid, dlc_bit, dlc_valid;
    logic       actvrmlen, resrmlen, busy, done;
    logic [2:0] setrmlen;
    logic [3:0] dlc;

    int checks   = 0;
    int failures = 0;
    int actv_cnt = 0;
    int done_cnt = 0;

    rmlen_seq #(.SET_GAP(1), .DLC_MSB_FIRST(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .sof       (sof),
        .abort     (abort),
        .rtr_bit   (rtr_bit),
        .rtr_valid (rtr_valid),
        .dlc_bit   (dlc_bit),
        .dlc_valid (dlc_valid),
        .actvrmlen (actvrmlen),
        .resrmlen  (resrmlen),
        .setrmlen  (setrmlen),
        .dlc       (dlc),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (actvrmlen) actv_cnt <= actv_cnt + 1;
            if (done)      done_cnt <= done_cnt + 1;
        end
    end

    typedef struct {
        logic       rtr;
        logic       rtr_in_clear;
        logic [3:0] dlc;
        int         n;
        logic [11:0] codes;   // first pulse in bits [2:0]
        int         lat;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic rtr, input logic rtr_in_clear, input string tag);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check({tag, "_clear_res"}, int'(resrmlen), 0);
        check({tag, "_clear_busy"}, int'(busy), 1);
        if (rtr_in_clear) begin
            rtr_valid = 1'b1;
            rtr_bit   = rtr;
        end
        tick();
        rtr_valid = 1'b0;
        rtr_bit   = 1'b0;
    endtask

    task automatic send_bits(input logic rtr, input logic rtr_in_clear, input logic [3:0] d);
        logic [3:0] v;
        v = d;
        for (int i = 0; i < 4; i++) begin
            dlc_valid = 1'b1;
            dlc_bit   = v[3-i];
            if (i == 0 && !rtr_in_clear) begin
                rtr_valid = 1'b1;
                rtr_bit   = rtr;
            end
            tick();
            dlc_valid = 1'b0;
            rtr_valid = 1'b0;
            rtr_bit   = 1'b0;
        end
    endtask

    // Called one cycle after the 4th dlc_valid; waits for done, logging set pulses.
    task automatic collect(output int n, output logic [11:0] codes, output int lat);
        n     = 0;
        codes = '0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (actvrmlen) begin
                if (n < 4) codes = codes | (12'(setrmlen) << (3 * n));
                n++;
            end
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int          n, lat, a0, d0;
        logic [11:0] codes;

        vecs[0] = '{1'b0, 1'b0, 4'd5,  2, 12'o0031, 5};
        vecs[1] = '{1'b1, 1'b1, 4'd8,  0, 12'o0000, 1};
        vecs[3] = '{1'b0, 1'b0, 4'd0,  0, 12'o0000, 1};
        vecs[5] = '{1'b0, 1'b0, 4'd8,  1, 12'o0004, 3};
        vecs[6] = '{1'b0, 1'b0, 4'd7,  3, 12'o0321, 7};
        vecs[7] = '{1'b1, 1'b0, 4'd15, 0, 12'o0000, 1};
`ifdef RMLEN_RAW_DLC_EN
        vecs[2] = '{1'b0, 1'b0, 4'd12, 2, 12'o0043, 5};
        vecs[4] = '{1'b0, 1'b0, 4'd15, 4, 12'o4321, 9};
        vecs[8] = '{1'b0, 1'b0, 4'd9,  2, 12'o0041, 5};
`else
        vecs[2] = '{1'b0, 1'b0, 4'd12, 1, 12'o0004, 3};
        vecs[4] = '{1'b0, 1'b0, 4'd15, 1, 12'o0004, 3};
        vecs[8] = '{1'b0, 1'b0, 4'd9,  1, 12'o0004, 3};
`endif

        reset = 1'b0;
        sof = 1'b0; abort = 1'b0;
        rtr_bit = 1'b0; rtr_valid = 1'b0; dlc_bit = 1'b0; dlc_valid = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("rst_actv", int'(actvrmlen), 0);
        check("rst_res",  int'(resrmlen), 1);
        check("rst_set",  int'(setrmlen), 0);
        check("rst_dlc",  int'(dlc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // DLC bits while idle are ignored
        dlc_valid = 1'b1; dlc_bit = 1'b1;
        tick(); tick();
        dlc_valid = 1'b0; dlc_bit = 1'b0;
        check("idle_ignore_dlc",  int'(dlc), 0);
        check("idle_ignore_busy", int'(busy), 0);

        for (int i = 0; i < NVEC; i++) begin
            start_frame(vecs[i].rtr, vecs[i].rtr_in_clear, $sformatf("v%0d", i));
            send_bits(vecs[i].rtr, vecs[i].rtr_in_clear, vecs[i].dlc);
            collect(n, codes, lat);
            check($sformatf("v%0d_npulse", i), n, vecs[i].n);
            check($sformatf("v%0d_codes", i), int'(codes), int'(vecs[i].codes));
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_dlc", i), int'(dlc), int'(vecs[i].dlc));
            tick();
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
        end

        // Abort in the GAP after the first LOAD of a DLC=15 frame
        start_frame(1'b0, 1'b0, "abort");
        send_bits(1'b0, 1'b0, 4'd15);
        check("abort_first_load", int'(actvrmlen), 1);
        a0 = actv_cnt + 1;
        d0 = done_cnt;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_actv", int'(actvrmlen), 0);
        check("abort_set",  int'(setrmlen), 0);
        repeat (10) tick();
        check("abort_no_more_pulses", actv_cnt - a0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_busy", int'(busy), 0);

        // sof during GAP of a DLC=7 frame restarts; new DLC=1 frame gives one pulse
        start_frame(1'b0, 1'b0, "restart");
        send_bits(1'b0, 1'b0, 4'd7);
        check("restart_load_code", int'(setrmlen), 1);
        tick();
        check("restart_gap_actv", int'(actvrmlen), 0);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("restart_clear_res",  int'(resrmlen), 0);
        check("restart_clear_actv", int'(actvrmlen), 0);
        tick();
        send_bits(1'b0, 1'b0, 4'd1);
        collect(n, codes, lat);
        check("restart_npulse", n, 1);
        check("restart_codes", int'(codes), 1);
        check("restart_latency", lat, 3);
        check("restart_dlc", int'(dlc), 1);
        tick();

        // Async reset while in LOAD
        start_frame(1'b0, 1'b0, "areset");
        send_bits(1'b0, 1'b0, 4'd5);
        check("areset_in_load", int'(actvrmlen), 1);
        #2 reset = 1'b0;
        #1;
        check("areset_actv", int'(actvrmlen), 0);
        check("areset_busy", int'(busy), 0);
        @(posedge clock);
        #3 reset = 1'b1;
        tick();
        check("areset_after_busy", int'(busy), 0);
        check("areset_after_dlc",  int'(dlc), 0);
        check("areset_after_res",  int'(resrmlen), 1);
        check("areset_after_done", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
